// File: rtl/param_delay_line.sv
// rtl/param_delay_line.sv - runtime-programmable register delay line with stall, tap select, flush and drop count
// Optional feature macro: DELAY_LINE_ZERO_LAT_EN (allows delay 0 as a combinational din->dout bypass).
module param_delay_line #(
    parameter int  WIDTH     = 8,
    parameter int  MAX_DEPTH = 16,
    localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DW-1:0]    delay_sel,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             dout_valid,
    output logic [WIDTH-1:0] dout,
    output logic             settle,
    output logic [7:0]       drop_cnt
);
    localparam int            SW    = DW + 9;
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);

    logic [MAX_DEPTH:1] valid_q, valid_d;
    logic [WIDTH-1:0]   data_q [1:MAX_DEPTH];
    logic [WIDTH-1:0]   data_d [1:MAX_DEPTH];
    logic [DW-1:0]      delay_q, delay_d;
    logic [DW-1:0]      settle_cnt_q, settle_cnt_d;
    logic [7:0]         drop_q, drop_d;

    logic [DW-1:0]      d_eff;
    logic               change;
    logic [SW-1:0]      pop;
    logic [SW-1:0]      drop_sum;
    logic               tap_valid;
    logic [WIDTH-1:0]   tap_data;

    always_comb begin
        d_eff = (delay_sel > MAX_D) ? MAX_D : delay_sel;
`ifndef DELAY_LINE_ZERO_LAT_EN
        if (d_eff == '0) d_eff = DW'(1);
`endif
    end

    assign change = en && (d_eff != delay_q);

    // Words visible at or before the active tap are the ones a flush discards.
    always_comb begin
        pop = '0;
        for (int i = 1; i <= MAX_DEPTH; i++) begin
            if ((DW'(i) <= delay_q) && valid_q[i]) pop = pop + SW'(1);
        end
        drop_sum = SW'(drop_q) + pop;
    end

    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        delay_d      = delay_q;
        settle_cnt_d = settle_cnt_q;
        drop_d       = drop_q;
        if (en) begin
            valid_d[1] = din_valid;
            data_d[1]  = din;
            for (int i = 2; i <= MAX_DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
            if (change) begin
                for (int i = 2; i <= MAX_DEPTH; i++) valid_d[i] = 1'b0;
                drop_d       = (drop_sum > SW'(255)) ? 8'hFF : drop_sum[7:0];
                delay_d      = d_eff;
                settle_cnt_d = (d_eff == '0) ? '0 : d_eff - DW'(1);
            end else if (settle_cnt_q != '0) begin
                settle_cnt_d = settle_cnt_q - DW'(1);
            end
        end
    end

    always_comb begin
        tap_valid = 1'b0;
        tap_data  = '0;
        for (int i = 1; i <= MAX_DEPTH; i++) begin
            if (delay_q == DW'(i)) begin
                tap_valid = valid_q[i];
                tap_data  = data_q[i];
            end
        end
    end

`ifdef DELAY_LINE_ZERO_LAT_EN
    assign dout_valid = (delay_q == '0) ? (din_valid & en) : tap_valid;
    assign dout       = (delay_q == '0) ? din : tap_data;
`else
    assign dout_valid = tap_valid;
    assign dout       = tap_data;
`endif

    assign settle   = (settle_cnt_q != '0);
    assign drop_cnt = drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 1; i <= MAX_DEPTH; i++) data_q[i] <= '0;
            delay_q      <= DW'(1);
            settle_cnt_q <= '0;
            drop_q       <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            delay_q      <= delay_d;
            settle_cnt_q <= settle_cnt_d;
            drop_q       <= drop_d;
        end
    end

endmodule

// File: tb/tb_param_delay_line.sv
// tb/tb_param_delay_line.sv - directed self-checking bench for param_delay_line
module tb_param_delay_line;
    localparam int WIDTH     = 8;
    localparam int MAX_DEPTH = 16;
    localparam int DW        = $clog2(MAX_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [DW-1:0]    delay_sel;
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             dout_valid;
    logic [WIDTH-1:0] dout;
    logic             settle;
    logic [7:0]       drop_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int drop_exp    = 0;

    param_delay_line #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .delay_sel(delay_sel),
        .din_valid(din_valid), .din(din),
        .dout_valid(dout_valid), .dout(dout), .settle(settle), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; delay_sel = 5'd1; din_valid = 1'b0; din = 8'h00;
        tick();
        tick();
        vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
        vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %h want 00", dout); end
        vectors++; if (settle !== 1'b0) begin miscompares++; $display("FAIL reset_settle: got %b want 0", settle); end
        vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_steady_latency();
        delay_sel = 5'd4;
        for (int t = 0; t < 12; t++) begin
            din_valid = (t < 8);
            din       = (t < 8) ? 8'(8'h11 + t) : 8'h00;
            tick();
            vectors++; if (dout_valid !== ((t >= 3) && (t <= 10))) begin miscompares++; $display("FAIL steady_valid t=%0d: got %b want %b", t, dout_valid, ((t >= 3) && (t <= 10))); end
            if ((t >= 3) && (t <= 10)) begin
                vectors++; if (dout !== 8'(8'h11 + t - 3)) begin miscompares++; $display("FAIL steady_data t=%0d: got %h want %h", t, dout, 8'(8'h11 + t - 3)); end
            end
            vectors++; if (settle !== (t < 3)) begin miscompares++; $display("FAIL steady_settle t=%0d: got %b want %b", t, settle, (t < 3)); end
        end
        vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL steady_drop: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_stall();
        delay_sel = 5'd3; din_valid = 1'b0; din = 8'h00;
        tick(); tick(); tick();
        vectors++; if (settle !== 1'b0) begin miscompares++; $display("FAIL stall_settle_pre: got %b want 0", settle); end
        din_valid = 1'b1; din = 8'hA5; tick();
        din = 8'h5A; tick();
        vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL stall_early: got %b want 0", dout_valid); end
        en = 1'b0; din = 8'hEE; delay_sel = 5'd7;
        for (int s = 0; s < 5; s++) begin
            tick();
            vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL stall_frozen s=%0d: got %b want 0", s, dout_valid); end
        end
        vectors++; if (settle !== 1'b0) begin miscompares++; $display("FAIL stall_sel_ignored: settle got %b want 0", settle); end
        en = 1'b1; delay_sel = 5'd3; din_valid = 1'b0; din = 8'h00;
        tick();
        vectors++; if ({dout_valid, dout} !== {1'b1, 8'hA5}) begin miscompares++; $display("FAIL stall_a5: got %b/%h want 1/a5", dout_valid, dout); end
        en = 1'b0;
        tick(); tick();
        vectors++; if ({dout_valid, dout} !== {1'b1, 8'hA5}) begin miscompares++; $display("FAIL stall_hold_a5: got %b/%h want 1/a5", dout_valid, dout); end
        en = 1'b1;
        tick();
        vectors++; if ({dout_valid, dout} !== {1'b1, 8'h5A}) begin miscompares++; $display("FAIL stall_5a: got %b/%h want 1/5a", dout_valid, dout); end
        tick();
        vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL stall_no_dup: got %b want 0", dout_valid); end
        vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL stall_drop: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_flush();
        delay_sel = 5'd8; din_valid = 1'b0; din = 8'h00;
        tick();
        for (int j = 0; j < 8; j++) begin
            din_valid = 1'b1; din = 8'(8'h80 + j);
            tick();
        end
        vectors++; if ({dout_valid, dout} !== {1'b1, 8'h80}) begin miscompares++; $display("FAIL flush_d8_out: got %b/%h want 1/80", dout_valid, dout); end
        delay_sel = 5'd2; din_valid = 1'b1; din = 8'h99;
        tick();
        vectors++; if (drop_cnt !== 8'd8) begin miscompares++; $display("FAIL flush_drop: got %0d want 8", drop_cnt); end
        vectors++; if (settle !== 1'b1) begin miscompares++; $display("FAIL flush_settle_hi: got %b want 1", settle); end
        vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_cleared: got %b want 0", dout_valid); end
        din_valid = 1'b0; din = 8'h00;
        tick();
        vectors++; if ({dout_valid, dout} !== {1'b1, 8'h99}) begin miscompares++; $display("FAIL flush_first: got %b/%h want 1/99", dout_valid, dout); end
        vectors++; if (settle !== 1'b0) begin miscompares++; $display("FAIL flush_settle_lo: got %b want 0", settle); end
        tick();
        vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL flush_after: got %b want 0", dout_valid); end
    endtask

    task automatic test_clamp();
        delay_sel = 5'(MAX_DEPTH + 3); din_valid = 1'b0; din = 8'h00;
        tick();
        din_valid = 1'b1; din = 8'hC3;
        tick();
        din_valid = 1'b0; din = 8'h00;
        for (int j = 1; j <= MAX_DEPTH - 1; j++) begin
            tick();
            if (j < MAX_DEPTH - 1) begin
                vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL clamp_early j=%0d: got %b want 0", j, dout_valid); end
            end else begin
                vectors++; if ({dout_valid, dout} !== {1'b1, 8'hC3}) begin miscompares++; $display("FAIL clamp_latency: got %b/%h want 1/c3", dout_valid, dout); end
            end
        end
        delay_sel = 5'(MAX_DEPTH + 4);
        tick();
        vectors++; if (drop_cnt !== 8'd8) begin miscompares++; $display("FAIL clamp_no_flush_drop: got %0d want 8", drop_cnt); end
        vectors++; if (settle !== 1'b0) begin miscompares++; $display("FAIL clamp_no_flush_settle: got %b want 0", settle); end
        drop_exp = 8;
    endtask

    task automatic test_saturation();
        int cur;
        int nxt;
        cur = MAX_DEPTH;
        for (int f = 0; f < 20; f++) begin
            delay_sel = 5'(cur); din_valid = 1'b1;
            for (int j = 0; j < cur; j++) begin
                din = 8'(j);
                tick();
            end
            nxt = (cur == MAX_DEPTH) ? MAX_DEPTH - 1 : MAX_DEPTH;
            delay_sel = 5'(nxt); din = 8'hF0;
            tick();
            drop_exp = (drop_exp + cur > 255) ? 255 : drop_exp + cur;
            vectors++; if (drop_cnt !== 8'(drop_exp)) begin miscompares++; $display("FAIL sat_drop f=%0d: got %0d want %0d", f, drop_cnt, drop_exp); end
            cur = nxt;
        end
        vectors++; if (drop_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_final: got %0d want 255", drop_cnt); end
    endtask

    task automatic test_zero_delay();
        delay_sel = 5'd0; din_valid = 1'b0; din = 8'h00;
        tick();
        vectors++; if (settle !== 1'b0) begin miscompares++; $display("FAIL zero_settle: got %b want 0", settle); end
        din_valid = 1'b1; din = 8'h3C;
`ifdef DELAY_LINE_ZERO_LAT_EN
        #1;
        vectors++; if ({dout_valid, dout} !== {1'b1, 8'h3C}) begin miscompares++; $display("FAIL zero_comb: got %b/%h want 1/3c", dout_valid, dout); end
        tick();
`else
        tick();
        vectors++; if ({dout_valid, dout} !== {1'b1, 8'h3C}) begin miscompares++; $display("FAIL zero_as_one: got %b/%h want 1/3c", dout_valid, dout); end
`endif
        din_valid = 1'b0; din = 8'h00;
    endtask

    task automatic test_reset_mid();
        delay_sel = 5'd6; din_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            din = 8'(8'h61 + j);
            tick();
        end
        vectors++; if (settle !== 1'b1) begin miscompares++; $display("FAIL rmid_settle_pre: got %b want 1", settle); end
        rst = 1'b1; delay_sel = 5'd3; din = 8'h64;
        tick();
        vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %b want 0", dout_valid); end
        vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL rmid_dout: got %h want 00", dout); end
        vectors++; if (settle !== 1'b0) begin miscompares++; $display("FAIL rmid_settle: got %b want 0", settle); end
        vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL rmid_drop: got %0d want 0", drop_cnt); end
        rst = 1'b0; delay_sel = 5'd1; din_valid = 1'b0; din = 8'h00;
        for (int j = 0; j < 3; j++) begin
            tick();
            vectors++; if ({dout_valid, dout} !== 9'h000) begin miscompares++; $display("FAIL rmid_d1 j=%0d: got %b/%h want 0/00", j, dout_valid, dout); end
        end
        delay_sel = 5'd6;
        tick();
        vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL rmid_drop_after: got %0d want 0", drop_cnt); end
        for (int j = 0; j < 8; j++) begin
            tick();
            vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_stale j=%0d: got %b want 0", j, dout_valid); end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; delay_sel = 5'd1; din_valid = 1'b0; din = 8'h00;
        test_reset();
        test_steady_latency();
        test_stall();
        test_flush();
        test_clamp();
        test_saturation();
        test_zero_delay();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
